// File: rtl/normalizer_pkg.sv
// Shared constants and types for the normalizer and its step datapath.
//   WORD_W       data word width
//   SHFT_W       shift-count width (matches the barrel shifter SHFT operand)
//   norm_state_t FSM state encoding
//   step_idx_t   binary-search step index k (4 down to 0)
package shifter_pkg;

   localparam int WORD_W = 32;
   localparam int SHFT_W = 5;

   typedef enum logic [1:0] {
      IDLE,
      STEP,
      DONE
   } norm_state_t;

   // k runs 4..0, so three bits are needed to hold the first value.
   typedef logic [2:0] step_idx_t;

   localparam step_idx_t K_FIRST = 3'd4;

endpackage

// File: rtl/normalizer_if.sv
// Handshake/data bundle between the normalizer and its requester.
//   IN, ARITH, START   request side (driven by master)
//   BUSY, DONE         status (driven by slave)
//   OUT, CNT, ZERO     results (driven by slave)
interface normalizer_if import shifter_pkg::*; ;

   logic [WORD_W-1:0] IN;
   logic              ARITH;
   logic              START;
   logic              BUSY;
   logic              DONE;
   logic [WORD_W-1:0] OUT;
   logic [SHFT_W-1:0] CNT;
   logic              ZERO;

   modport slave (
      input  IN, ARITH, START,
      output BUSY, DONE, OUT, CNT, ZERO
   );

   modport master (
      output IN, ARITH, START,
      input  BUSY, DONE, OUT, CNT, ZERO
   );

endinterface

// File: rtl/normalizer_step.sv
// One binary-search step of the normalizer (purely combinational).
// Ports:
//   w     current work word
//   k     step index, step size s = 2^k
//   mode  1 = redundant-sign test, 0 = leading-zero test
//   pass  the top s bits may be shifted out without losing information
//   w_shl w shifted left by s, zero-filled
// Build option: NORMALIZER_ARITH_EN enables the sign-equality test; without
// it mode is ignored and only the leading-zero test exists.
module norm_step
   import shifter_pkg::*;
(
   input  logic [WORD_W-1:0] w,
   input  step_idx_t         k,
   input  logic              mode,
   output logic              pass,
   output logic [WORD_W-1:0] w_shl
);

   logic [5:0]        s;
   logic [WORD_W-1:0] head_mask;

`ifdef NORMALIZER_ARITH_EN
   logic [WORD_W-1:0] sign_mask;
`else
   logic unused_mode;
   assign unused_mode = mode;
`endif

   always_comb begin
      s         = 6'd1 << k;
      // covers W[31:32-s]
      head_mask = ~({WORD_W{1'b1}} >> s);
      w_shl     = w << s;
      pass      = (w & head_mask) == '0;
`ifdef NORMALIZER_ARITH_EN
      // covers W[31:31-s]: the s bits to drop plus the new sign bit
      sign_mask = ~({WORD_W{1'b1}} >> (s + 6'd1));
      if (mode)
         pass = ((w & sign_mask) == '0) || ((w & sign_mask) == sign_mask);
`endif
   end

endmodule

// File: rtl/normalizer.sv
// Normalizer: finds the largest left shift that drops only redundant leading
// bits (leading zeros, or redundant sign bits in arithmetic mode) using a
// 5-step binary search, one step per clock.
// Ports:
//   CLK  rising-edge clock
//   RST  asynchronous active-high reset
//   bus  normalizer_if.slave: IN/ARITH/START request, BUSY/DONE status,
//        OUT (normalized word), CNT (shift count), ZERO (no significant bits)
// Build option: NORMALIZER_ARITH_EN honours ARITH; otherwise logical only.
//
// state | meaning
// IDLE  | waiting for START, results held
// STEP  | one search step per cycle, k = 4..0
// DONE  | one-cycle result pulse, START accepted here too
module normalizer
   import shifter_pkg::*;
(
   input logic         CLK,
   input logic         RST,
   normalizer_if.slave bus
);

   norm_state_t       state;
   logic [WORD_W-1:0] w;
   logic [SHFT_W-1:0] cnt;
   step_idx_t         k;
   logic              mode;
   logic              zero_r;
   logic              busy_r;
   logic              done_r;

   logic              mode_in;
   logic              zero_in;
   logic              step_pass;
   logic [WORD_W-1:0] step_w;
   logic              accept;

`ifdef NORMALIZER_ARITH_EN
   assign mode_in = bus.ARITH;
   assign zero_in = (bus.IN == '0) || (bus.ARITH && (bus.IN == '1));
`else
   logic unused_arith;
   assign unused_arith = bus.ARITH;
   assign mode_in      = 1'b0;
   assign zero_in      = (bus.IN == '0);
`endif

   assign accept = bus.START && ((state == IDLE) || (state == DONE));

   norm_step u_step (
      .w     (w),
      .k     (k),
      .mode  (mode),
      .pass  (step_pass),
      .w_shl (step_w)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state  <= IDLE;
         w      <= '0;
         cnt    <= '0;
         k      <= '0;
         mode   <= 1'b0;
         zero_r <= 1'b0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         case (state)
            STEP: begin
               if (step_pass) begin
                  w      <= step_w;
                  cnt[k] <= 1'b1;
               end
               if (k == '0) begin
                  state  <= DONE;
                  busy_r <= 1'b0;
                  done_r <= 1'b1;
               end else begin
                  k <= step_idx_t'(k - 3'd1);
               end
            end
            default: begin
               done_r <= 1'b0;
               state  <= IDLE;
               if (accept) begin
                  w      <= bus.IN;
                  cnt    <= '0;
                  mode   <= mode_in;
                  k      <= K_FIRST;
                  zero_r <= zero_in;
                  busy_r <= 1'b1;
                  state  <= STEP;
               end
            end
         endcase
      end
   end

   assign bus.OUT  = w;
   assign bus.CNT  = cnt;
   assign bus.ZERO = zero_r;
   assign bus.BUSY = busy_r;
   assign bus.DONE = done_r;

`ifdef FORMAL
   logic [WORD_W-1:0] in_latched;
   logic              done_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         in_latched <= '0;
         done_q     <= 1'b0;
      end else begin
         if (accept)
            in_latched <= bus.IN;
         done_q <= done_r;
      end
   end

   always_comb begin
      if (!RST) begin
         assert (!(busy_r && done_r));
         assert (!(done_r && done_q));
         if (done_r)
            assert (w == (in_latched << cnt));
      end
   end
`endif

endmodule

// File: tb/tb_normalizer.sv
module tb_normalizer;

   logic CLK;
   logic RST;
   int   checks = 0;
   int   errors = 0;

   normalizer_if bus ();

   normalizer dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Reference: count leading zeros (logical) or redundant sign bits (arith),
   // capped at 31, then shift.
   function automatic void model(input logic [31:0] din, input logic ar,
                                 output logic [4:0] c, output logic [31:0] o,
                                 output logic z);
      int  n;
      logic m;
`ifdef NORMALIZER_ARITH_EN
      m = ar;
`else
      m = 1'b0;
      if (ar) m = 1'b0;
`endif
      n = 0;
      if (!m) begin
         while (n < 32 && din[31-n] == 1'b0) n++;
         z = (din == 32'h0);
      end else begin
         while (n < 32 && din[31-n] == din[31]) n++;
         n = n - 1;
         z = (din == 32'h0) || (din == 32'hFFFF_FFFF);
      end
      if (n > 31) n = 31;
      c = 5'(n);
      o = din << n;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_op(input logic [31:0] din, input logic ar);
      logic [4:0]  ec;
      logic [31:0] eo;
      logic        ez;
      model(din, ar, ec, eo, ez);
      @(negedge CLK);
      bus.IN = din; bus.ARITH = ar; bus.START = 1'b1;
      @(posedge CLK);
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         chk("busy_high", 32'(bus.BUSY), 32'd1);
         chk("done_low", 32'(bus.DONE), 32'd0);
         bus.IN    = $urandom;
         bus.ARITH = 1'($urandom);
         bus.START = (i < 4) ? 1'($urandom) : 1'b0;
      end
      @(negedge CLK);
      chk("done_pulse", 32'(bus.DONE), 32'd1);
      chk("busy_end", 32'(bus.BUSY), 32'd0);
      chk("cnt", 32'(bus.CNT), 32'(ec));
      chk("out", bus.OUT, eo);
      chk("zero", 32'(bus.ZERO), 32'(ez));
      @(negedge CLK);
      chk("done_once", 32'(bus.DONE), 32'd0);
      chk("idle_busy", 32'(bus.BUSY), 32'd0);
      chk("cnt_hold", 32'(bus.CNT), 32'(ec));
      chk("out_hold", bus.OUT, eo);
   endtask

   initial begin
      logic [4:0]  ec;
      logic [31:0] eo;
      logic        ez;

      RST = 1'b1;
      bus.IN = '0; bus.ARITH = 1'b0; bus.START = 1'b0;
      repeat (2) @(negedge CLK);
      chk("rst_out", bus.OUT, 32'h0);
      chk("rst_cnt", 32'(bus.CNT), 32'd0);
      chk("rst_zero", 32'(bus.ZERO), 32'd0);
      chk("rst_busy", 32'(bus.BUSY), 32'd0);
      chk("rst_done", 32'(bus.DONE), 32'd0);
      RST = 1'b0;

      // reset mid-search
      @(negedge CLK);
      bus.IN = 32'h0000_0000; bus.ARITH = 1'b0; bus.START = 1'b1;
      @(posedge CLK);
      #1 bus.START = 1'b0;
      repeat (2) @(posedge CLK);
      #1 RST = 1'b1;
      #1;
      chk("mid_rst_out", bus.OUT, 32'h0);
      chk("mid_rst_cnt", 32'(bus.CNT), 32'd0);
      chk("mid_rst_zero", 32'(bus.ZERO), 32'd0);
      chk("mid_rst_busy", 32'(bus.BUSY), 32'd0);
      @(negedge CLK);
      RST = 1'b0;

      // directed vectors
      do_op(32'h0001_0000, 1'b0);
      chk("dir_cnt15", 32'(bus.CNT), 32'd15);
      do_op(32'h0000_0000, 1'b0);
      chk("dir_zero_cnt", 32'(bus.CNT), 32'd31);
      chk("dir_zero_flag", 32'(bus.ZERO), 32'd1);
      do_op(32'h0000_0001, 1'b0);
      chk("dir_one_out", bus.OUT, 32'h8000_0000);
      do_op(32'hFFFF_8000, 1'b1);
      do_op(32'h0000_0001, 1'b1);
      do_op(32'hFFFF_FFFF, 1'b1);
      do_op(32'hFFFF_0000, 1'b1);
`ifndef NORMALIZER_ARITH_EN
      chk("cfg_cnt", 32'(bus.CNT), 32'd0);
      chk("cfg_out", bus.OUT, 32'hFFFF_0000);
      chk("cfg_zero", 32'(bus.ZERO), 32'd0);
`else
      chk("arith_ffff0000_cnt", 32'(bus.CNT), 32'd15);
`endif

      // random single operations, including sparse and sign-heavy words
      for (int r = 0; r < 24; r++) begin
         logic [31:0] v;
         v = $urandom >> $urandom_range(31, 0);
         if ($urandom_range(1, 0) == 1) v = ~v;
         do_op(v, 1'($urandom));
      end

      // START held high: one result per 6 cycles, IN changes every cycle
      @(negedge CLK);
      bus.START = 1'b1;
      for (int g = 0; g < 4; g++) begin
         logic [31:0] v;
         logic        a;
         v = $urandom >> $urandom_range(31, 0);
         a = 1'($urandom);
         bus.IN = v; bus.ARITH = a;
         model(v, a, ec, eo, ez);
         @(posedge CLK);
         for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("bb_busy", 32'(bus.BUSY), 32'd1);
            chk("bb_done_low", 32'(bus.DONE), 32'd0);
            bus.IN    = $urandom;
            bus.ARITH = 1'($urandom);
         end
         @(negedge CLK);
         chk("bb_done", 32'(bus.DONE), 32'd1);
         chk("bb_busy_end", 32'(bus.BUSY), 32'd0);
         chk("bb_cnt", 32'(bus.CNT), 32'(ec));
         chk("bb_out", bus.OUT, eo);
         chk("bb_zero", 32'(bus.ZERO), 32'(ez));
      end
      bus.START = 1'b0;
      repeat (2) @(negedge CLK);
      chk("final_idle_busy", 32'(bus.BUSY), 32'd0);
      chk("final_idle_done", 32'(bus.DONE), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
